// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues one req/ack fetch at a time, holds a returned
// instruction while decode stalls, and squashes in-flight fetches on a flush.
module ifetch_ctrl #(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = 'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            stall_d,
    input  logic            flush_d,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            pc_en,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [1:0]      o_dbg_state
);

    // Handshake: a request is live while mem_req=1; mem_addr is frozen for its
    // whole duration; the cycle with mem_ack=1 completes it and mem_req falls at
    // the following edge. Only one request is ever outstanding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_hold_instr;
    logic [XLEN-1:0] r_hold_pc;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc;

    logic            w_accept;
    logic            w_issue;
    logic            w_capture;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_load_pc;

    assign w_accept = (r_state == S_REQ) && mem_ack && !stall_d && !flush_d;
    assign pc_en    = reset && (flush_d || w_accept || ((r_state == S_HOLD) && !stall_d));

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_load_instr = NOP;
        w_load_pc    = '0;
        case (r_state)
            // A flush in IDLE lets the PC take the target before the first fetch.
            S_IDLE: begin
                if (!flush_d) begin
                    w_next_state = S_REQ;
                    w_issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (flush_d) begin
                        w_next_state = S_IDLE;
                    end else if (stall_d) begin
                        w_next_state = S_HOLD;
                        w_capture    = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                        w_load       = 1'b1;
                        w_load_instr = mem_rdata;
                        w_load_pc    = r_mem_addr;
                    end
                end else if (flush_d) begin
                    w_next_state = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush_d) begin
                    w_next_state = S_IDLE;
                end else if (!stall_d) begin
                    w_next_state = S_IDLE;
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_load_pc    = r_hold_pc;
                end
            end
            S_DROP: begin
                if (mem_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hold_instr <= NOP;
            r_hold_pc    <= '0;
        end else begin
            r_mem_req <= (w_next_state == S_REQ) || (w_next_state == S_DROP);
            if (w_issue) begin
                r_mem_addr <= pc;
            end
            if (w_capture) begin
                r_hold_instr <= mem_rdata;
                r_hold_pc    <= r_mem_addr;
            end
        end
    end

    // IF/ID: flush beats stall, stall beats a load, anything else is a bubble.
    always_ff @(posedge clk) begin
        if (!reset || flush_d) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
        end else if (!stall_d) begin
            r_ifid_valid <= w_load;
            r_ifid_instr <= w_load_instr;
            r_ifid_pc    <= w_load_pc;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign ifid_valid  = r_ifid_valid;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc     = r_ifid_pc;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random stall/flush/reset/wait traffic,
// checked every cycle against a transaction-level model and a queue of expected IF/ID.
module tb_ifetch_ctrl;

    localparam int              XLEN = 32;
    localparam logic [XLEN-1:0] NOP  = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] tb_pc;
    logic            stall_d;
    logic            flush_d;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            pc_en;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    logic [XLEN-1:0] br_target;
    int              fixed_wait;
    bit              in_req = 1'b0;
    int              cnt = 0;
    logic [XLEN-1:0] data_q[$];

    // Model: a request is outstanding (possibly dead after a flush), or an instruction
    // is parked waiting for decode, or nothing is going on.
    bit              m_out, m_dead, m_held, m_rst;
    logic [XLEN-1:0] m_addr, m_hi, m_hp;
    bit              m_vld, ld;
    logic [XLEN-1:0] m_instr, m_ipc, ld_i, ld_p;
    logic [2*XLEN:0] exp_q[$];

    ifetch_ctrl #(.XLEN(XLEN), .NOP(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (tb_pc),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc_en      (pc_en),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // PC register of the surrounding core
    always @(posedge clk) begin
        if (!reset) tb_pc <= '0;
        else if (pc_en) tb_pc <= flush_d ? br_target : tb_pc + 32'd4;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic mem_respond();
        if (!mem_req) begin
            in_req  = 1'b0;
            mem_ack = 1'b0;
        end else begin
            if (!in_req) begin
                in_req = 1'b1;
                cnt = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
            end
            if (cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
                in_req    = 1'b0;
            end else begin
                cnt--;
                mem_ack = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_respond();
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (!reset) begin
            m_out = 0; m_dead = 0; m_held = 0; m_rst = 1;
            m_addr = '0; m_vld = 0; m_instr = NOP; m_ipc = '0;
            exp_q.delete();
        end else begin
            m_rst = 0; ld = 0; ld_i = NOP; ld_p = '0;
            if (m_out) begin
                if (mem_ack) begin
                    m_out = 0;
                    if (!m_dead && !flush_d) begin
                        if (stall_d) begin
                            m_held = 1; m_hi = mem_rdata; m_hp = m_addr;
                        end else begin
                            ld = 1; ld_i = mem_rdata; ld_p = m_addr;
                        end
                    end
                    m_dead = 0;
                end else if (flush_d) begin
                    m_dead = 1;
                end
            end else if (m_held) begin
                if (flush_d) m_held = 0;
                else if (!stall_d) begin
                    m_held = 0; ld = 1; ld_i = m_hi; ld_p = m_hp;
                end
            end else if (!flush_d) begin
                m_out = 1; m_addr = tb_pc;
            end
            if (flush_d) begin
                m_vld = 0; m_instr = NOP; m_ipc = '0;
            end else if (!stall_d) begin
                m_vld = ld; m_instr = ld_i; m_ipc = ld_p;
            end
        end
        exp_q.push_back({m_vld, m_ipc, m_instr});
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [2*XLEN:0] e;
        logic            exp_pc_en;
        logic [1:0]      exp_state;
        if (check_en) begin
            exp_pc_en = reset && (flush_d || (m_out && !m_dead && mem_ack && !stall_d)
                                  || (m_held && !stall_d));
            exp_state = m_out ? (m_dead ? 2'd3 : 2'd1) : (m_held ? 2'd2 : 2'd0);
            check("mem_req", 64'(mem_req), 64'(m_out));
            if (m_out || m_rst) check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("pc_en", 64'(pc_en), 64'(exp_pc_en));
            check("state", 64'(dbg_state), 64'(exp_state));
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("ifid_valid", 64'(ifid_valid), 64'(e[2*XLEN]));
                check("ifid_pc", 64'(ifid_pc), 64'(e[2*XLEN-1:XLEN]));
                check("ifid_instr", 64'(ifid_instr), 64'(e[XLEN-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 0; stall_d = 0; flush_d = 0; mem_ack = 0; mem_rdata = '0;
        br_target = '0; fixed_wait = 0;
        data_q.push_back(32'hA5A5A5A5);
        data_q.push_back(32'h12345678);

        // reset values
        tick();
        check_en = 1'b1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_ifid_valid", 64'(ifid_valid), 64'd0);
        check("rst_ifid_instr", 64'(ifid_instr), 64'(NOP));
        check("rst_ifid_pc", 64'(ifid_pc), 64'd0);
        check("rst_pc_en", 64'(pc_en), 64'd0);
        tick();
        check("rst2_pc_en", 64'(pc_en), 64'd0);
        reset = 1;
        check("post_rst_mem_req", 64'(mem_req), 64'd0);
        tick();
        check("first_req", 64'(mem_req), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);

        // zero-wait fetch
        tick();
        check("zw0_valid", 64'(ifid_valid), 64'd1);
        check("zw0_instr", 64'(ifid_instr), 64'hA5A5A5A5);
        check("zw0_pc", 64'(ifid_pc), 64'd0);
        tick();
        check("zw_bubble", 64'(ifid_valid), 64'd0);
        check("zw1_addr", 64'(mem_addr), 64'd4);
        tick();
        check("zw1_valid", 64'(ifid_valid), 64'd1);
        check("zw1_instr", 64'(ifid_instr), 64'h12345678);
        check("zw1_pc", 64'(ifid_pc), 64'd4);

        // stall at ack
        data_q.push_back(32'hDEADBEEF);
        tick();
        check("st_addr", 64'(mem_addr), 64'd8);
        stall_d = 1;
        #1;
        check("st_ack_pc_en", 64'(pc_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold_state", 64'(dbg_state), 64'd2);
            #1;
            check("st_hold_pc_en", 64'(pc_en), 64'd0);
        end
        stall_d = 0;
        #1;
        check("st_release_pc_en", 64'(pc_en), 64'd1);
        tick();
        check("st_valid", 64'(ifid_valid), 64'd1);
        check("st_instr", 64'(ifid_instr), 64'hDEADBEEF);
        check("st_pc", 64'(ifid_pc), 64'd8);

        // flush in flight: redirect to 0x10, then flush the 0x10 fetch to 0x40
        flush_d = 1; br_target = 32'h10; fixed_wait = 3;
        #1;
        check("fl_idle_pc_en", 64'(pc_en), 64'd1);
        tick();
        flush_d = 0;
        check("fl_idle_state", 64'(dbg_state), 64'd0);
        tick();
        check("fl_req", 64'(mem_req), 64'd1);
        check("fl_addr", 64'(mem_addr), 64'h10);
        flush_d = 1; br_target = 32'h40;
        tick();
        flush_d = 0;
        check("fl_drop_state", 64'(dbg_state), 64'd3);
        fixed_wait = 0;
        for (int i = 0; i < 10 && mem_req; i++) begin
            check("fl_drop_valid", 64'(ifid_valid), 64'd0);
            tick();
        end
        check("fl_drop_done", 64'(mem_req), 64'd0);
        check("fl_stale_valid", 64'(ifid_valid), 64'd0);
        tick();
        check("fl_new_addr", 64'(mem_addr), 64'h40);

        // flush and stall together in HOLD
        stall_d = 1;
        tick();
        check("fs_hold", 64'(dbg_state), 64'd2);
        flush_d = 1; br_target = 32'h80;
        #1;
        check("fs_pc_en", 64'(pc_en), 64'd1);
        tick();
        flush_d = 0; stall_d = 0;
        check("fs_valid", 64'(ifid_valid), 64'd0);
        check("fs_instr", 64'(ifid_instr), 64'(NOP));
        check("fs_state", 64'(dbg_state), 64'd0);

        // reset mid-request, then a late ack
        fixed_wait = 3;
        tick();
        check("rm_req_state", 64'(dbg_state), 64'd1);
        reset = 0;
        tick();
        reset = 1;
        check("rm_mem_req", 64'(mem_req), 64'd0);
        check("rm_state", 64'(dbg_state), 64'd0);
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        #1;
        check("rm_late_pc_en", 64'(pc_en), 64'd0);
        tick();
        check("rm_late_valid", 64'(ifid_valid), 64'd0);
        check("rm_late_state", 64'(dbg_state), 64'd1);

        // random traffic
        fixed_wait = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            reset     = ($urandom_range(0, 63) != 0);
            stall_d   = ($urandom_range(0, 3) == 0);
            flush_d   = ($urandom_range(0, 7) == 0);
            br_target = $urandom & 32'hFFFF_FFFC;
            if (!mem_req && $urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
        tick();
        reset = 1; stall_d = 0; flush_d = 0;
        tick();
        tick();
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the pipelined RISC-V core. It sits between the PC register and a multi-cycle instruction memory with a req/ack handshake, and drives the IF/ID stage. It generates the PC register enable, holds one returned instruction while decode is stalled, and discards in-flight fetches on a branch flush.

## Interface

**Parameters**
- `XLEN`, 32: address and instruction width.
- `NOP`, 32'h00000013: instruction value loaded into IF/ID on reset, bubble or flush.

**Ports**
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low reset. It is sampled only on the `clk` rising edge.
- `pc`  in  XLEN: current PC, taken from the PC register output.
- `stall_d`  in  1: decode stall from the hazard unit. IF/ID must hold.
- `flush_d`  in  1: branch/jump taken. Squash IF/ID and any fetch in flight.
- `mem_req`  out  1: instruction memory request.
- `mem_addr`  out  XLEN: request address. It is registered and stable while `mem_req`=1.
- `mem_ack`  in  1: memory has returned data this cycle. It is only meaningful while `mem_req`=1.
- `mem_rdata`  in  XLEN: returned instruction. It is valid in the `mem_ack` cycle.
- `pc_en`  out  1: combinational enable to the PC register.
- `ifid_valid`  out  1: the IF/ID instruction is real, not a bubble.
- `ifid_instr`  out  XLEN: IF/ID instruction.
- `ifid_pc`  out  XLEN: PC of `ifid_instr`.

## Operation

**States**
- `IDLE`: ready to issue a new fetch.
- `REQ`: a request is outstanding.
- `HOLD`: data has been received, but decode is stalled.
- `DROP`: a request is outstanding, but it has been flushed.

**Reset** (`reset`=0 at an edge):
- state becomes `IDLE`.
- `mem_req`=0, `mem_addr`=0.
- `ifid_valid`=0, `ifid_instr`=`NOP`, `ifid_pc`=0.
- the hold buffer is cleared.
- `pc_en` is 0 while `reset`=0.
- Any outstanding request is abandoned. The memory must tolerate `mem_req` falling without an ack.

**Definition.** `accept` = (state=`REQ`) & `mem_ack` & !`stall_d` & !`flush_d`.

**PC enable.** `pc_en` = `flush_d` | `accept` | (state=`HOLD` & !`stall_d`).

**State transitions.** Where more than one condition applies, `flush_d` takes priority over `stall_d`.
- `IDLE` → `REQ`. At this edge: `mem_addr`<=`pc`, `mem_req`<=1. `pc` is stable in `IDLE` because `pc_en` is 0 unless `flush_d`=1.
  - With `flush_d`=1 in `IDLE`: stay in `IDLE`, so the PC loads the branch target first.
- `REQ`, no ack, `flush_d`=1 → `DROP`.
- `REQ`, no ack, `flush_d`=0 → stay in `REQ`.
- `REQ`, ack, `flush_d`=1 → `IDLE`. The data is discarded.
- `REQ`, ack, `stall_d`=1 → `HOLD`. `mem_rdata` and `mem_addr` are captured into the hold buffer.
- `REQ`, `accept` → `IDLE`. IF/ID loads {1, `mem_rdata`, `mem_addr`}.
- `HOLD`, `flush_d`=1 → `IDLE`. The buffer is discarded.
- `HOLD`, `stall_d`=1 → stay in `HOLD`.
- `HOLD`, `stall_d`=0 → `IDLE`. IF/ID loads the buffer with valid=1.
- `DROP`: `mem_req` stays 1 and `mem_addr` is unchanged. On ack → `IDLE`; the data is discarded.
- `mem_req` is 0 in every state except `REQ` and `DROP`. It drops at the edge that leaves those states.

**IF/ID register update** (every edge, in priority order):
1. `reset`=0: clear to the reset values.
2. `flush_d`=1: load {0, `NOP`, 0}.
3. `stall_d`=1: hold.
4. A load event as listed above: load that entry.
5. Otherwise: load a bubble {0, `NOP`, 0}.

## Timing

- Ack received in cycle N:
  - IF/ID is valid in cycle N+1.
  - The PC has updated in cycle N+1.
  - The FSM is in `IDLE` in cycle N+1.
  - The next `mem_req` rises in cycle N+2.
- With a zero-wait memory (ack in the first `REQ` cycle), throughput is one instruction every 2 cycles.
- A memory with W wait cycles gives throughput of one instruction every W+2 cycles.
- `mem_addr` never changes while `mem_req`=1.
- `pc_en` and `flush_d` are in the same cycle. The PC loads the target at that edge, and the first fetch of the target is issued from `IDLE` on the following cycle.
- Exactly one outstanding request at a time. There is no request pipelining.
- `stall_d` and `flush_d` together: flush wins. IF/ID is squashed and the held or in-flight data is discarded.

## Test plan

- **Reset values.** Hold `reset`=0 for 2 cycles, then release.
  - During reset: all outputs at their reset values, `pc_en`=0.
  - First cycle after release: `mem_req`=0.
  - Next cycle: `mem_req`=1 with `mem_addr`=`pc`.
- **Zero-wait fetch.** Testbench PC register starts at 0 and is driven by `pc_en` with pc+4; memory acks immediately and returns 32'hA5A5A5A5, then 32'h12345678.
  - `ifid_pc`/`ifid_instr` = 0/A5A5A5A5, then 4/12345678.
  - `ifid_valid` pulses every 2 cycles.
- **Stall at ack.** `stall_d`=1 in the ack cycle for data 32'hDEADBEEF at PC 8, held for 3 cycles.
  - FSM enters `HOLD` with `pc_en`=0 throughout.
  - On release: `ifid_instr`=DEADBEEF, `ifid_pc`=8.
- **Flush in flight.** Request to PC 0x10, ack after 3 cycles; `flush_d`=1 pulsed in the first `REQ` cycle with target 0x40.
  - FSM goes through `DROP`; the stale data never appears in IF/ID (`ifid_valid`=0).
  - The next request has `mem_addr`=0x40.
- **Flush and stall together** while in `HOLD`.
  - The buffer is discarded: `ifid_valid`=0, `ifid_instr`=`NOP`.
  - `pc_en`=1 in that cycle.
- **Reset mid-request.** Assert `reset`=0 while in `REQ`.
  - Next cycle: `mem_req`=0 and state `IDLE`.
  - A late ack while `mem_req`=0 is ignored.
